// File: rtl/ip_pkt_pkg.sv
// Shared constants and FSM state type for the IPv4 receive parser.
// Used by ip_packet_rx; the optional IP_RX_CHECKSUM_VERIFY_EN build needs nothing extra here.
package ip_pkt_pkg;
  localparam int          ETH_HDR_SIZE_BYTES = 14;
  localparam int          IP_HDR_SIZE_BYTES  = 20;
  localparam int          DATA_SIZE_BYTES    = 26;
  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_VERSION_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTOCOL        = 8'h00;
  localparam int          BYTE_CNT_WIDTH     = 5;

  typedef logic [BYTE_CNT_WIDTH-1:0] byte_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ETH_HDR,
    ST_IP_HDR,
    ST_USER_DATA,
    ST_DROP,
    ST_HOLD
  } rx_state_t;

  function automatic byte_idx_t last_idx(input int size_bytes);
    return byte_idx_t'(size_bytes - 1);
  endfunction
endpackage

// File: rtl/counter_sync_reset.sv
// Up-counter with a synchronous clear (priority over enable) and async active-low reset.
module counter_sync_reset #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/ipv4_checksum_accumulator.sv
// Byte-serial ones'-complement sum of big-endian 16-bit words (even byte = high half).
// o_sum_next already includes the byte presented on an odd-parity cycle.
module ipv4_checksum_accumulator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_odd,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum_next
);
  logic [15:0] r_sum;
  logic [7:0]  r_hi;
  logic [16:0] w_add;

  assign w_add      = {1'b0, r_sum} + {1'b0, r_hi, i_byte};
  // a single end-around fold cannot carry again: the folded value stays <= 0xFFFF
  assign o_sum_next = i_odd ? (w_add[15:0] + {15'd0, w_add[16]}) : r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_hi  <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
      r_hi  <= '0;
    end else if (i_en) begin
      if (i_odd) begin
        r_sum <= o_sum_next;
      end else begin
        r_hi <= i_byte;
      end
    end
  end
endmodule

// File: rtl/ip_packet_rx.sv
// Parses Ethernet/IPv4/26-byte payload frames, filters for this node, hands the result over valid/ready.
// Define IP_RX_CHECKSUM_VERIFY_EN to also reject frames whose IPv4 header checksum is wrong.
module ip_packet_rx
  import ip_pkt_pkg::*;
#(
  parameter int AXI_S_DATA_WIDTH = 8,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
  input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
  input  logic                        MAC_DATA_VALID,
  output logic                        MAC_DATA_READY,
  input  logic                        MAC_DATA_LAST,
  input  logic                        MAC_DATA_TUSER,
  output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
  output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0] SENDER_MESSAGE,
  output logic                        MESSAGE_VALID,
  input  logic                        MESSAGE_READY,
  output logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT
);
  rx_state_t r_state, w_state_next;
  byte_idx_t w_cnt;
  logic      w_beat, w_eth_phase, w_cnt_clr, w_drop_inc, w_accept;
  logic      w_mac_ok, w_eth_bad, w_ip_bad, w_csum_bad;
  logic      r_oversize, w_oversize_next, r_msg_valid;

  logic [MAC_ADDR_WIDTH-9:0]   r_dst_mac;
  logic [IP_ADDR_WIDTH-9:0]    r_dst_ip;
  logic [MAC_ADDR_WIDTH-1:0]   r_src_mac, r_sender_mac, w_dst_mac;
  logic [IP_ADDR_WIDTH-1:0]    r_src_ip, r_sender_ip, w_dst_ip;
  logic [ACCEL_DATA_WIDTH-1:0] r_msg, r_sender_msg;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

  assign MAC_DATA_READY     = (r_state != ST_HOLD);
  assign w_beat             = MAC_DATA_VALID && MAC_DATA_READY;
  assign w_eth_phase        = (r_state == ST_IDLE) || (r_state == ST_ETH_HDR);
  assign SENDER_MAC_ADDRESS = r_sender_mac;
  assign SENDER_IP_ADDRESS  = r_sender_ip;
  assign SENDER_MESSAGE     = r_sender_msg;
  assign MESSAGE_VALID      = r_msg_valid;
  assign DROP_COUNT         = r_drop_count;

  counter_sync_reset #(.WIDTH(BYTE_CNT_WIDTH)) u_byte_cnt (
    .clk     (ACLK),
    .rst_n   (ARESET),
    .i_clr   (w_cnt_clr),
    .i_en    (w_beat),
    .o_count (w_cnt)
  );

`ifdef IP_RX_CHECKSUM_VERIFY_EN
  logic [15:0] w_csum_next;
  ipv4_checksum_accumulator u_csum (
    .clk        (ACLK),
    .rst_n      (ARESET),
    .i_clr      (r_state != ST_IP_HDR),
    .i_en       (w_beat && (r_state == ST_IP_HDR)),
    .i_odd      (w_cnt[0]),
    .i_byte     (MAC_DATA_IN),
    .o_sum_next (w_csum_next)
  );
  assign w_csum_bad = (w_csum_next != 16'hFFFF);
`else
  assign w_csum_bad = 1'b0;
`endif

  // Address comparisons use the byte on the wire for the final (most significant) byte.
  assign w_dst_mac = {MAC_DATA_IN, r_dst_mac};
  assign w_dst_ip  = {MAC_DATA_IN, r_dst_ip};
  assign w_mac_ok  = (w_dst_mac == ACCELERATOR_MAC_ADDRESS) || (w_dst_mac == '1);
  assign w_eth_bad = ((w_cnt == byte_idx_t'(5))  && !w_mac_ok)
                  || ((w_cnt == byte_idx_t'(12)) && (MAC_DATA_IN != ETHERTYPE_IPV4[15:8]))
                  || ((w_cnt == byte_idx_t'(13)) && (MAC_DATA_IN != ETHERTYPE_IPV4[7:0]));
  assign w_ip_bad  = ((w_cnt == byte_idx_t'(0)) && (MAC_DATA_IN != IP_VERSION_IHL))
                  || ((w_cnt == byte_idx_t'(9)) && (MAC_DATA_IN != IP_PROTOCOL))
                  || ((w_cnt == last_idx(IP_HDR_SIZE_BYTES))
                      && ((w_dst_ip != ACCELERATOR_IP_ADDRESS) || w_csum_bad));

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_clr       = 1'b0;
    w_drop_inc      = 1'b0;
    w_accept        = 1'b0;
    w_oversize_next = r_oversize;
    case (r_state)
      ST_IDLE, ST_ETH_HDR: begin
        if (w_beat) begin
          w_state_next = ST_ETH_HDR;
          if (MAC_DATA_LAST || w_eth_bad) begin
            w_state_next = MAC_DATA_LAST ? ST_IDLE : ST_DROP;
            w_cnt_clr    = 1'b1;
            w_drop_inc   = 1'b1;
          end else if (w_cnt == last_idx(ETH_HDR_SIZE_BYTES)) begin
            w_state_next = ST_IP_HDR;
            w_cnt_clr    = 1'b1;
          end
        end
      end
      ST_IP_HDR: begin
        if (w_beat) begin
          if (MAC_DATA_LAST || w_ip_bad) begin
            w_state_next = MAC_DATA_LAST ? ST_IDLE : ST_DROP;
            w_cnt_clr    = 1'b1;
            w_drop_inc   = 1'b1;
          end else if (w_cnt == last_idx(IP_HDR_SIZE_BYTES)) begin
            w_state_next = ST_USER_DATA;
            w_cnt_clr    = 1'b1;
          end
        end
      end
      ST_USER_DATA: begin
        if (w_beat && (w_cnt == last_idx(DATA_SIZE_BYTES))) begin
          w_cnt_clr = 1'b1;
          if (!MAC_DATA_LAST) begin
            // oversize: the drop is counted when the frame finally ends
            w_state_next    = ST_DROP;
            w_oversize_next = 1'b1;
          end else if (MAC_DATA_TUSER) begin
            w_state_next = ST_IDLE;
            w_drop_inc   = 1'b1;
          end else begin
            w_state_next = ST_HOLD;
            w_accept     = 1'b1;
          end
        end else if (w_beat && MAC_DATA_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_clr    = 1'b1;
          w_drop_inc   = 1'b1;
        end
      end
      ST_DROP: begin
        if (w_beat && MAC_DATA_LAST) begin
          w_state_next    = ST_IDLE;
          w_cnt_clr       = 1'b1;
          w_drop_inc      = r_oversize;
          w_oversize_next = 1'b0;
        end
      end
      ST_HOLD: begin
        if (r_msg_valid && MESSAGE_READY) begin
          w_state_next = ST_IDLE;
          w_cnt_clr    = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_dst_mac    <= '0;
      r_dst_ip     <= '0;
      r_src_mac    <= '0;
      r_src_ip     <= '0;
      r_msg        <= '0;
      r_sender_mac <= '0;
      r_sender_ip  <= '0;
      r_sender_msg <= '0;
      r_msg_valid  <= 1'b0;
      r_drop_count <= '0;
      r_oversize   <= 1'b0;
    end else begin
      if (w_beat) begin
        for (int k = 0; k < 5; k++) begin
          if (w_eth_phase && (w_cnt == byte_idx_t'(k))) r_dst_mac[8*k +: 8] <= MAC_DATA_IN;
        end
        for (int k = 0; k < 6; k++) begin
          if (w_eth_phase && (w_cnt == byte_idx_t'(k + 6))) r_src_mac[8*k +: 8] <= MAC_DATA_IN;
        end
        for (int k = 0; k < 4; k++) begin
          if ((r_state == ST_IP_HDR) && (w_cnt == byte_idx_t'(k + 12))) r_src_ip[8*k +: 8] <= MAC_DATA_IN;
        end
        for (int k = 0; k < 3; k++) begin
          if ((r_state == ST_IP_HDR) && (w_cnt == byte_idx_t'(k + 16))) r_dst_ip[8*k +: 8] <= MAC_DATA_IN;
        end
        if ((r_state == ST_USER_DATA) && (w_cnt == byte_idx_t'(0)))
          r_msg[ACCEL_DATA_WIDTH-1:8] <= MAC_DATA_IN[ACCEL_DATA_WIDTH-9:0];
        if ((r_state == ST_USER_DATA) && (w_cnt == byte_idx_t'(1)))
          r_msg[7:0] <= MAC_DATA_IN;
      end
      if (w_accept) begin
        r_sender_mac <= r_src_mac;
        r_sender_ip  <= r_src_ip;
        r_sender_msg <= r_msg;
        r_msg_valid  <= 1'b1;
      end else if (r_msg_valid && MESSAGE_READY) begin
        r_msg_valid <= 1'b0;
      end
      if (w_drop_inc && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
      r_oversize <= w_oversize_next;
    end
  end
endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed + randomized frame bench for ip_packet_rx with a frame-level accept/drop reference model.
// Honours IP_RX_CHECKSUM_VERIFY_EN in its model when the design is built with it.
`timescale 1ns/1ps
module tb_ip_packet_rx;
  localparam logic [47:0] ACC_MAC = 48'h0A0B0C0D0E0F;
  localparam logic [31:0] ACC_IP  = 32'h0A000001;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [7:0]  MAC_DATA_IN = 8'h00;
  logic        MAC_DATA_VALID = 1'b0;
  logic        MAC_DATA_READY;
  logic        MAC_DATA_LAST = 1'b0;
  logic        MAC_DATA_TUSER = 1'b0;
  logic [47:0] SENDER_MAC_ADDRESS;
  logic [31:0] SENDER_IP_ADDRESS;
  logic [9:0]  SENDER_MESSAGE;
  logic        MESSAGE_VALID;
  logic        MESSAGE_READY = 1'b0;
  logic [15:0] DROP_COUNT;

  int          errors = 0;
  int          checks = 0;
  int          model_drops = 0;
  logic [7:0]  fr [0:69];
  int          fr_len;
  logic        fr_tu;
  logic [47:0] exp_smac;
  logic [31:0] exp_sip;
  logic [9:0]  exp_msg;

  ip_packet_rx dut (
    .ACLK                    (ACLK),
    .ARESET                  (ARESET),
    .ACCELERATOR_IP_ADDRESS  (ACC_IP),
    .ACCELERATOR_MAC_ADDRESS (ACC_MAC),
    .MAC_DATA_IN             (MAC_DATA_IN),
    .MAC_DATA_VALID          (MAC_DATA_VALID),
    .MAC_DATA_READY          (MAC_DATA_READY),
    .MAC_DATA_LAST           (MAC_DATA_LAST),
    .MAC_DATA_TUSER          (MAC_DATA_TUSER),
    .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
    .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
    .SENDER_MESSAGE          (SENDER_MESSAGE),
    .MESSAGE_VALID           (MESSAGE_VALID),
    .MESSAGE_READY           (MESSAGE_READY),
    .DROP_COUNT              (DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hdr_sum();
    int s = 0;
    for (int w = 0; w < 10; w++) s += int'({fr[14+2*w], fr[15+2*w]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [47:0] smac, input logic [15:0] et,
                       input logic [7:0] ver, input logic [7:0] proto, input logic [31:0] sip,
                       input logic [31:0] dip, input logic [9:0] msg);
    logic [15:0] c;
    for (int i = 0; i < 70; i++) fr[i] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      fr[k]   = dmac[8*k +: 8];
      fr[6+k] = smac[8*k +: 8];
    end
    fr[12] = et[15:8];
    fr[13] = et[7:0];
    fr[14] = ver;
    fr[23] = proto;
    for (int k = 0; k < 4; k++) begin
      fr[26+k] = sip[8*k +: 8];
      fr[30+k] = dip[8*k +: 8];
    end
    fr[34] = {fr[34][7:2], msg[9:8]};
    fr[35] = msg[7:0];
    fr[24] = 8'h00;
    fr[25] = 8'h00;
    c = ~16'(hdr_sum());
    fr[24] = c[15:8];
    fr[25] = c[7:0];
    fr_len = 60;
    fr_tu  = 1'b0;
  endtask

  // Frame-level rules: exactly 60 bytes, good fields, for us, no TUSER on LAST.
  function automatic logic model_accept();
    logic [47:0] d;
    logic [31:0] dip;
    logic        ok;
    for (int k = 0; k < 6; k++) begin
      d[8*k +: 8]        = fr[k];
      exp_smac[8*k +: 8] = fr[6+k];
    end
    for (int k = 0; k < 4; k++) begin
      dip[8*k +: 8]     = fr[30+k];
      exp_sip[8*k +: 8] = fr[26+k];
    end
    exp_msg = {fr[34][1:0], fr[35]};
    ok = (fr_len == 60) && !fr_tu && ((d == ACC_MAC) || (d == 48'hFFFF_FFFF_FFFF))
      && (fr[12] == 8'h08) && (fr[13] == 8'h00) && (fr[14] == 8'h45) && (fr[23] == 8'h00)
      && (dip == ACC_IP);
`ifdef IP_RX_CHECKSUM_VERIFY_EN
    ok = ok && (hdr_sum() == 32'hFFFF);
`endif
    return ok;
  endfunction

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input logic last, input logic tu);
    int guard = 0;
    if ($urandom_range(0, 3) == 0) @(negedge ACLK);
    MAC_DATA_VALID = 1'b1;
    MAC_DATA_IN    = b;
    MAC_DATA_LAST  = last;
    MAC_DATA_TUSER = tu;
    while (MAC_DATA_READY !== 1'b1 && guard < 200) begin
      @(negedge ACLK);
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge ACLK);
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    MAC_DATA_TUSER = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < fr_len; i++) send_byte(fr[i], i == fr_len - 1, (i == fr_len - 1) ? fr_tu : 1'b0);
  endtask

  task automatic expect_result(input string tag, input int hold, input logic pend_en, input logic [7:0] pend_b);
    logic acc;
    acc = model_accept();
    if (!acc) model_drops = (model_drops < 65535) ? model_drops + 1 : 65535;
    $display("frame %s len=%0d tuser=%0b expect=%s drops=%0d", tag, fr_len, fr_tu, acc ? "accept" : "drop", model_drops);
    chk({tag, "_valid"}, 64'(MESSAGE_VALID), 64'(acc));
    chk({tag, "_drops"}, 64'(DROP_COUNT), 64'(model_drops));
    if (acc) begin
      chk({tag, "_smac"}, 64'(SENDER_MAC_ADDRESS), 64'(exp_smac));
      chk({tag, "_sip"}, 64'(SENDER_IP_ADDRESS), 64'(exp_sip));
      chk({tag, "_msg"}, 64'(SENDER_MESSAGE), 64'(exp_msg));
      MAC_DATA_VALID = pend_en;
      MAC_DATA_IN    = pend_b;
      for (int c = 0; c < hold; c++) begin
        chk({tag, "_hold_rdy"}, 64'(MAC_DATA_READY), 64'd0);
        @(negedge ACLK);
        chk({tag, "_hold_valid"}, 64'(MESSAGE_VALID), 64'd1);
      end
      chk({tag, "_stable"}, {6'd0, SENDER_MESSAGE, SENDER_MAC_ADDRESS}, {6'd0, exp_msg, exp_smac});
      MESSAGE_READY = 1'b1;
      @(negedge ACLK);
      MESSAGE_READY  = 1'b0;
      MAC_DATA_VALID = 1'b0;
      chk({tag, "_valid_clr"}, 64'(MESSAGE_VALID), 64'd0);
      chk({tag, "_rdy_back"}, 64'(MAC_DATA_READY), 64'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rdy"}, 64'(MAC_DATA_READY), 64'd1);
    chk({tag, "_valid"}, 64'(MESSAGE_VALID), 64'd0);
    chk({tag, "_senders"}, {SENDER_MESSAGE, SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS} != '0, 64'd0);
    chk({tag, "_drops"}, 64'(DROP_COUNT), 64'd0);
  endtask

  initial begin
    int          kind;
    logic [47:0] sm;
    logic [31:0] si;
    logic [9:0]  mg;

    #1;
    check_reset_values("rst");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);

    // 1: good unicast frame
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h2A5);
    fr[34] = 8'h02;
    send_frame();
    expect_result("t1_unicast", 2, 1'b0, 8'h00);

    // 2: back-to-back, result held for 10 cycles while the next frame waits
    build(ACC_MAC, 48'h0102030405AB, 16'h0800, 8'h45, 8'h00, 32'hC0A80103, ACC_IP, 10'h155);
    send_frame();
    expect_result("t2_first", 10, 1'b1, ACC_MAC[7:0]);
    build(ACC_MAC, 48'hA1A2A3A4A5A6, 16'h0800, 8'h45, 8'h00, 32'hC0A80104, ACC_IP, 10'h3C3);
    send_frame();
    expect_result("t2_second", 1, 1'b0, 8'h00);

    // 3: wrong ethertype, wrong dst IP, broadcast
    build(ACC_MAC, 48'h112233445566, 16'h86DD, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h011);
    send_frame();
    expect_result("t3_ethertype", 0, 1'b0, 8'h00);
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, 32'h0A000002, 10'h022);
    send_frame();
    expect_result("t3_dstip", 0, 1'b0, 8'h00);
    build(48'hFFFF_FFFF_FFFF, 48'h665544332211, 16'h0800, 8'h45, 8'h00, 32'hC0A801FE, ACC_IP, 10'h200);
    send_frame();
    expect_result("t3_bcast", 1, 1'b0, 8'h00);

    // 4: runt, oversize, bad-frame flag, then good
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h0F0);
    fr_len = 30;
    send_frame();
    expect_result("t4_runt", 0, 1'b0, 8'h00);
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h0F1);
    fr_len = 70;
    send_frame();
    expect_result("t4_oversize", 0, 1'b0, 8'h00);
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h0F2);
    fr_tu = 1'b1;
    send_frame();
    expect_result("t4_tuser", 0, 1'b0, 8'h00);
    build(ACC_MAC, 48'h778899AABBCC, 16'h0800, 8'h45, 8'h00, 32'hC0A80199, ACC_IP, 10'h3FF);
    send_frame();
    expect_result("t4_good", 1, 1'b0, 8'h00);

    // 5: reset in the middle of a frame; the tail arrives as a new frame
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h123);
    for (int i = 0; i < 20; i++) send_byte(fr[i], 1'b0, 1'b0);
    #2 ARESET = 1'b0;
    #1;
    check_reset_values("t5_rst");
    model_drops = 0;
    @(negedge ACLK);
    ARESET = 1'b1;
    for (int i = 0; i < 40; i++) fr[i] = fr[i+20];
    fr_len = 40;
    send_frame();
    expect_result("t5_tail", 0, 1'b0, 8'h00);
    build(ACC_MAC, 48'h0A0A0A0A0A0A, 16'h0800, 8'h45, 8'h00, 32'hC0A80107, ACC_IP, 10'h2AA);
    send_frame();
    expect_result("t5_after", 1, 1'b0, 8'h00);

    // 6: corrupted header checksum, then correct one
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h1B1);
    fr[24] = fr[24] ^ 8'h01;
    send_frame();
    expect_result("t6_badcsum", 1, 1'b0, 8'h00);
    build(ACC_MAC, 48'h112233445566, 16'h0800, 8'h45, 8'h00, 32'hC0A80102, ACC_IP, 10'h1B2);
    send_frame();
    expect_result("t6_goodcsum", 1, 1'b0, 8'h00);

    // randomized frames
    for (int n = 0; n < 16; n++) begin
      kind = int'($urandom_range(0, 9));
      sm   = {16'($urandom), 32'($urandom)};
      si   = 32'($urandom);
      mg   = 10'($urandom);
      build(ACC_MAC, sm, 16'h0800, 8'h45, 8'h00, si, ACC_IP, mg);
      case (kind)
        1: build(48'hFFFF_FFFF_FFFF, sm, 16'h0800, 8'h45, 8'h00, si, ACC_IP, mg);
        2: build(ACC_MAC, sm, 16'h0806, 8'h45, 8'h00, si, ACC_IP, mg);
        3: build(ACC_MAC, sm, 16'h0800, 8'h46, 8'h00, si, ACC_IP, mg);
        4: build(ACC_MAC, sm, 16'h0800, 8'h45, 8'h11, si, ACC_IP, mg);
        5: build(ACC_MAC, sm, 16'h0800, 8'h45, 8'h00, si, ACC_IP ^ (32'h1 << $urandom_range(0, 31)), mg);
        6: fr_len = int'($urandom_range(1, 59));
        7: fr_tu = 1'b1;
        8: fr_len = int'($urandom_range(61, 70));
        9: build(ACC_MAC ^ (48'h1 << $urandom_range(0, 47)), sm, 16'h0800, 8'h45, 8'h00, si, ACC_IP, mg);
        default: ;
      endcase
      send_frame();
      expect_result("rnd", int'($urandom_range(0, 3)), 1'b0, 8'h00);
    end

    // drop-counter saturation with back-to-back one-byte runts
    MAC_DATA_VALID = 1'b1;
    MAC_DATA_LAST  = 1'b1;
    MAC_DATA_IN    = 8'h00;
    repeat (65540) @(negedge ACLK);
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    model_drops = (model_drops + 65540 > 65535) ? 65535 : model_drops + 65540;
    $display("saturation burst of 65540 runts expect drops=%0d", model_drops);
    chk("sat_drops", 64'(DROP_COUNT), 64'(model_drops));
    chk("sat_valid", 64'(MESSAGE_VALID), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ip_packet_rx.md
Name: ip_packet_rx

Overview:
Receive-side counterpart of the accelerator's IP transmitter. Consumes a byte-wide AXI-Stream frame from the MAC and parses the Ethernet header, the IPv4 header and the fixed 26-byte user payload. Filters frames addressed to the accelerator and presents the sender's MAC address, IP address and 10-bit message to the accelerator core through a valid/ready handshake. Sits between the MAC RX stream and the accelerator request logic.

Parameters:
AXI_S_DATA_WIDTH, 8, stream byte width (only 8 supported)
IP_ADDR_WIDTH, 32, IPv4 address width
MAC_ADDR_WIDTH, 48, MAC address width
ACCEL_DATA_WIDTH, 10, message width delivered to the accelerator
DROP_COUNT_WIDTH, 16, width of the saturating dropped-frame counter

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-low reset
ACCELERATOR_IP_ADDRESS  in  32  own IP address, little-endian byte order
ACCELERATOR_MAC_ADDRESS  in  48  own MAC address, little-endian byte order
MAC_DATA_IN  in  8  stream data
MAC_DATA_VALID  in  1  stream valid
MAC_DATA_READY  out  1  stream ready
MAC_DATA_LAST  in  1  last byte of frame
MAC_DATA_TUSER  in  1  bad-frame flag, sampled with LAST
SENDER_MAC_ADDRESS  out  48  source MAC of the accepted frame
SENDER_IP_ADDRESS  out  32  source IP of the accepted frame
SENDER_MESSAGE  out  10  payload message
MESSAGE_VALID  out  1  result valid
MESSAGE_READY  in  1  accelerator accepts result
DROP_COUNT  out  16  number of dropped frames, saturating

Behaviour:
- One clock, ACLK. ARESET is asynchronous and active-low.
- Reset values: state IDLE, byte counter 0, MAC_DATA_READY 1, MESSAGE_VALID 0, all SENDER_* outputs 0, DROP_COUNT 0.
- A beat is a cycle with MAC_DATA_VALID && MAC_DATA_READY. Parsing, counting and capture happen only on beats.
- State ETH_HDR (IDLE is its count-0 entry), bytes 0-13:
  - Bytes 0-5 are the destination MAC; byte k maps to bits [8k+7:8k].
  - Bytes 6-11 are the source MAC, captured in the same byte order.
  - Bytes 12-13 are the ethertype, big-endian, and must equal 0x0800.
- State IP_HDR, bytes 0-19:
  - Byte 0 must be 0x45.
  - Byte 9 (protocol) must be 0x00.
  - Bytes 12-15 are the source IP (little-endian), captured.
  - Bytes 16-19 are the destination IP (little-endian).
  - All other bytes are ignored.
- State USER_DATA, bytes 0-25:
  - SENDER_MESSAGE[9:8] = byte0[1:0].
  - SENDER_MESSAGE[7:0] = byte1.
  - Remaining bytes are ignored.
- Full frame is 60 bytes. LAST is expected exactly on USER_DATA byte 25.
- Accept conditions:
  - Destination MAC equals ACCELERATOR_MAC_ADDRESS or 0xFFFFFFFFFFFF.
  - Destination IP equals ACCELERATOR_IP_ADDRESS.
  - All the field checks above pass.
  - TUSER is low on the LAST beat.
- Field mismatch: on the beat where the check fails, go to DROP and discard bytes until the LAST beat; DROP_COUNT += 1 on that beat; then return to IDLE.
- LAST before byte 60 (runt): drop immediately, count +1, go to IDLE.
- No LAST on byte 60 (oversize): go to DROP, count +1 at the LAST beat.
- TUSER=1 on LAST of an otherwise good frame: drop, count +1.
- Counter saturation: DROP_COUNT saturates at 0xFFFF; further drops leave it unchanged.
- Good LAST beat:
  - Latch captured fields into the SENDER_* registers.
  - MESSAGE_VALID rises the next cycle (1-cycle latency), and the block enters HOLD.
- HOLD:
  - MAC_DATA_READY=0 (back-pressure).
  - SENDER_* outputs are stable while MESSAGE_VALID=1.
  - When MESSAGE_VALID && MESSAGE_READY: MESSAGE_VALID=0 and MAC_DATA_READY=1 on the next cycle; state returns to IDLE.
- MAC_DATA_READY is 1 in every state except HOLD.
- Reset mid-frame: all state is cleared. The tail of the interrupted frame is parsed as a new frame and is expected to fail the field checks and be counted as a drop. No resync logic.

Optional Feature:
IP_RX_CHECKSUM_VERIFY_EN
- Defined: accumulate the ones'-complement 16-bit sum of the 20 IP header bytes as big-endian words. If the final sum ≠ 0xFFFF, the frame is treated as a field mismatch at IP_HDR byte 19 (DROP, count +1).
- Undefined: the checksum bytes are ignored; no adder logic is present.

Decomposition:
- Package ip_pkt_pkg holds:
  - ETH_HDR_SIZE_BYTES=14, IP_HDR_SIZE_BYTES=20, DATA_SIZE_BYTES=26
  - ETHERTYPE_IPV4=16'h0800, IP_VERSION_IHL=8'h45, IP_PROTOCOL=8'h00
  - the state enum type
- The state byte counter reuses counter_sync_reset.
- One sub-module, ipv4_checksum_accumulator: byte-serial ones'-complement adder with clear, enable and byte-parity inputs. It is instantiated only under IP_RX_CHECKSUM_VERIFY_EN.

Test Plan:
1. Good unicast frame: dst MAC = ACCELERATOR_MAC_ADDRESS = 0x0A0B0C0D0E0F, src MAC 0x112233445566, src IP 0xC0A80102, payload bytes 0x02, 0xA5 -> SENDER_MESSAGE=0x2A5 and SENDER_* match; MESSAGE_VALID 1 cycle after LAST; DROP_COUNT=0.
2. Back-to-back frames with MESSAGE_READY held low for 10 cycles -> MAC_DATA_READY=0 for those cycles, outputs stable, no bytes lost; second frame parsed after acceptance.
3. Wrong ethertype 0x86DD, then wrong dst IP, then broadcast dst MAC -> first two dropped (DROP_COUNT=2, no MESSAGE_VALID); broadcast frame accepted.
4. Runt (LAST on byte 30), oversize (70 bytes), good frame with TUSER=1 on LAST -> DROP_COUNT=3, no MESSAGE_VALID, and the next good frame is accepted.
5. ARESET pulsed at byte 20 of a frame -> outputs return to reset values; the tail of that frame is dropped (DROP_COUNT=1); the following frame is accepted.
6. With IP_RX_CHECKSUM_VERIFY_EN: correct header checksum -> accepted; checksum byte 10 XOR 0x01 -> dropped, DROP_COUNT=1. Without the macro, the same corrupted frame is accepted.
